uart_frame_ctrl: RTL and testbench

Frame-level controller placed directly behind the UART byte receiver. It consumes the received byte stream (`data`/`done`) and the bit-rate `tick`, and parses packets of the form SYNC, LEN, payload[LEN], CSUM. Accepted payload is held in an internal buffer and handed to the command logic through a valid/ack handshake. Inter-byte timeouts, bad lengths, checksum failures and overruns are reported as error pulses and counters.

---
 rtl/uart_frame_ctrl_if.sv | 49 ++++
 rtl/uart_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_frame_ctrl_if
//
// Signal bundle between the UART frame controller and its surroundings.
//   Inputs to the controller : tick, byte_data, byte_valid, frame_ack, rd_addr
//   Outputs from controller  : rd_data, frame_valid, frame_len, busy,
//                              crc_err, len_err, timeout_err, drop_cnt
//
// Modports:
//   master - the side that feeds bytes and consumes frames (receiver + command
//            logic, or a testbench)
//   slave  - the frame controller itself
// ----------------------------------------------------------------------------
interface uart_frame_ctrl_if #(
  parameter int AW = 4
);

  // byte stream from the receiver
  logic          tick;
  logic [7:0]    byte_data;
  logic          byte_valid;

  // frame hand-off to the command logic
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [7:0]    frame_len;

  // status and error reporting
  logic          busy;
  logic          crc_err;
  logic          len_err;
  logic          timeout_err;
  logic [7:0]    drop_cnt;

  modport master (
    output tick, byte_data, byte_valid, frame_ack, rd_addr,
    input  rd_data, frame_valid, frame_len, busy,
           crc_err, len_err, timeout_err, drop_cnt
  );

  modport slave (
    input  tick, byte_data, byte_valid, frame_ack, rd_addr,
    output rd_data, frame_valid, frame_len, busy,
           crc_err, len_err, timeout_err, drop_cnt
  );

endinterface

// File: rtl/uart_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_frame_ctrl
//
// Frame-level parser sitting behind the UART byte receiver. Packets have the
// form SYNC, LEN, payload[LEN], CSUM where CSUM is the XOR of LEN and every
// payload byte. An accepted payload is held in an internal buffer until the
// consumer acknowledges it; bytes arriving while a frame is held are dropped
// and counted.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   bus (slave)    uart_frame_ctrl_if:
//     tick         one-cycle bit-rate strobe, drives the inter-byte timeout
//     byte_data    received byte, qualified by byte_valid
//     byte_valid   one-cycle strobe from the receiver
//     frame_ack    consumer releases the held frame
//     rd_addr      payload buffer read address
//     rd_data      buffer[rd_addr], registered (1-cycle latency)
//     frame_valid  a complete, checked frame is held
//     frame_len    payload length of the current / held frame
//     busy         parser is not idle
//     crc_err      1-cycle pulse, checksum mismatch
//     len_err      1-cycle pulse, LEN == 0 or LEN > MAX_LEN
//     timeout_err  1-cycle pulse, inter-byte timeout inside a frame
//     drop_cnt     bytes dropped while a frame was held, saturating at 255
// ----------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         AW            = 4,
  parameter int         TIMEOUT_TICKS = 30
) (
  input logic              clk,
  input logic              rst,
  uart_frame_ctrl_if.slave bus
);

  localparam int         TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam int         DEPTH     = 1 << AW;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0]    state;
  logic [7:0]    cnt;          // payload bytes received so far
  logic [7:0]    csum;         // running XOR of LEN and payload
  logic [TW-1:0] to_cnt;       // ticks since the last byte inside a frame
  logic [7:0]    frame_len_q;
  logic          frame_valid_q;
  logic          crc_err_q;
  logic          len_err_q;
  logic          timeout_err_q;
  logic [7:0]    drop_cnt_q;
  logic [7:0]    rd_data_q;

  logic [7:0]    mem [DEPTH];

  logic in_frame;
  logic to_expire;
  logic wr_en;

  // The timeout only runs between SYNC and CSUM.
  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);

  // A byte in the same cycle as the expiring tick wins, so the expiry is
  // qualified with !byte_valid.
  assign to_expire = in_frame && !bus.byte_valid && bus.tick && (to_cnt == TO_LAST);

  assign wr_en = (state == ST_PAYLOAD) && bus.byte_valid;

  // NOTE: the payload buffer has no reset; its contents are only meaningful
  // below frame_len, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt[AW-1:0]] <= bus.byte_data;
    end
  end

  // NOTE: every register in this block is assigned with <= so that all of them
  // see the pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      csum          <= '0;
      to_cnt        <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      // Error outputs are single-cycle pulses.
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;

      rd_data_q <= mem[bus.rd_addr];

      // Inter-byte timer: held at zero outside a frame, cleared by any byte.
      if (!in_frame || bus.byte_valid || to_expire) begin
        to_cnt <= '0;
      end else if (bus.tick) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (to_expire) begin
        timeout_err_q <= 1'b1;
        state         <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // Anything other than SYNC is line noise and ignored silently.
            if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
              state <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (bus.byte_valid) begin
              if ((bus.byte_data == 8'd0) || (bus.byte_data > MAX_LEN_B)) begin
                len_err_q <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                frame_len_q <= bus.byte_data;
                csum        <= bus.byte_data;
                cnt         <= '0;
                state       <= ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            // SYNC_BYTE is ordinary data here; there is no resync.
            if (bus.byte_valid) begin
              csum <= csum ^ bus.byte_data;
              cnt  <= cnt + 8'd1;
              if (cnt == frame_len_q - 8'd1) begin
                state <= ST_CSUM;
              end
            end
          end

          ST_CSUM: begin
            if (bus.byte_valid) begin
              if (bus.byte_data == csum) begin
                frame_valid_q <= 1'b1;
                state         <= ST_HOLD;
              end else begin
                crc_err_q <= 1'b1;
                state     <= ST_IDLE;
              end
            end
          end

          ST_HOLD: begin
            // Buffer and length stay frozen; incoming bytes are only counted,
            // including one that lands in the ack cycle.
            if (bus.byte_valid && (drop_cnt_q != 8'hFF)) begin
              drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (bus.frame_ack) begin
              frame_valid_q <= 1'b0;
              state         <= ST_IDLE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.crc_err     = crc_err_q;
  assign bus.len_err     = len_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_ctrl
//
// Self-checking bench for uart_frame_ctrl: a table of directed single-cycle
// vectors, hand-written multi-cycle sequences (max length, timeout, overrun,
// asynchronous reset) and a randomized phase compared cycle by cycle against
// a queue-based packet model.
// ----------------------------------------------------------------------------
module tb_uart_frame_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TO   = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_ctrl_if #(.AW(4)) bus ();

  uart_frame_ctrl #(
    .SYNC_BYTE     (SYNC),
    .MAX_LEN       (MAXL),
    .AW            (4),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {frame_valid, frame_len, busy, crc_err, len_err, timeout_err, drop_cnt}
  function automatic logic [20:0] status();
    return {bus.frame_valid, bus.frame_len, bus.busy, bus.crc_err,
            bus.len_err, bus.timeout_err, bus.drop_cnt};
  endfunction

  function automatic logic [20:0] st(input logic v, input logic [7:0] len, input logic b,
                                     input logic [2:0] err, input logic [7:0] drop);
    return {v, len, b, err, drop};
  endfunction

  // Apply inputs at a negedge, let one posedge pass, return at the next negedge.
  task automatic cyc(input logic tk, input logic bv, input logic [7:0] bd,
                     input logic ack, input logic [3:0] addr);
    bus.tick       = tk;
    bus.byte_valid = bv;
    bus.byte_data  = bd;
    bus.frame_ack  = ack;
    bus.rd_addr    = addr;
    @(negedge clk);
  endtask

  task automatic sb(input logic [7:0] b);
    cyc(1'b0, 1'b1, b, 1'b0, 4'd0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic       bv;
    logic [7:0] bd;
    logic       ack;
    logic [3:0] addr;
    logic       chk_rd;
    logic [7:0] rd;
    logic       v;
    logic [7:0] len;
    logic       busy;
    logic [2:0] err;   // {crc, len, timeout}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic bv, input logic [7:0] bd, input logic ack,
                              input logic [3:0] addr, input logic chk_rd, input logic [7:0] rd,
                              input logic v, input logic [7:0] len, input logic busy,
                              input logic [2:0] err);
    vec_t r;
    r.bv = bv; r.bd = bd; r.ack = ack; r.addr = addr; r.chk_rd = chk_rd; r.rd = rd;
    r.v = v; r.len = len; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic fill_table();
    // good frame after garbage
    tbl.push_back(mk(1, 8'h5A, 0, 0, 0, 0,     0, 0, 0, 3'b000));
    tbl.push_back(mk(1, 8'h7E, 0, 0, 0, 0,     0, 0, 0, 3'b000));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0,     0, 0, 1, 3'b000));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0,     1, 3, 1, 3'b000));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h11, 1, 3, 1, 3'b000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h22, 1, 3, 1, 3'b000));
    tbl.push_back(mk(0, 8'h00, 0, 2, 1, 8'h33, 1, 3, 1, 3'b000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,     0, 3, 0, 3'b000));
    // bad checksum, then pulse must drop again
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h04, 0, 0, 0, 0,     0, 3, 0, 3'b100));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,     0, 3, 0, 3'b000));
    // following good frame accepted
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0,     0, 3, 1, 3'b000));
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0,     0, 1, 1, 3'b000));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0,     0, 1, 1, 3'b000));
    tbl.push_back(mk(1, 8'h54, 0, 0, 1, 8'h55, 1, 1, 1, 3'b000));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h55, 0, 1, 0, 3'b000));
    // ack outside HOLD is ignored
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,     0, 1, 0, 3'b000));
    // length limits
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0,     0, 1, 1, 3'b000));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0,     0, 1, 0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,     0, 1, 0, 3'b000));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0,     0, 1, 1, 3'b000));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0,     0, 1, 0, 3'b010));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,     0, 1, 0, 3'b000));
  endtask

  // ------------------------------------------------------------------ model
  // Collects the bytes of the frame in progress in a queue and judges the
  // frame from its contents once LEN or the final byte is known.
  logic [7:0] mq[$];
  logic [7:0] m_pay[256];
  bit         m_hold;
  int         m_flen, m_plen, m_drop, m_ticks;
  bit         m_crc, m_lerr, m_to;

  task automatic model_reset();
    mq.delete();
    m_hold = 0; m_flen = 0; m_plen = 0; m_drop = 0; m_ticks = 0;
    m_crc = 0; m_lerr = 0; m_to = 0;
  endtask

  task automatic model_step(input bit tk, input bit bv, input logic [7:0] bd, input bit ack);
    logic [7:0] x;
    int         l;
    m_crc = 0; m_lerr = 0; m_to = 0;
    if (m_hold) begin
      if (bv && m_drop < 255) m_drop++;
      if (ack) m_hold = 0;
    end else if (mq.size() == 0) begin
      m_ticks = 0;
      if (bv && bd == SYNC) mq.push_back(bd);
    end else if (bv) begin
      m_ticks = 0;
      mq.push_back(bd);
      l = int'(mq[1]);
      if (mq.size() == 2) begin
        if (l == 0 || l > MAXL) begin
          m_lerr = 1;
          mq.delete();
        end else begin
          m_flen = l;
        end
      end else if (mq.size() == l + 3) begin
        x = 8'h00;
        for (int i = 1; i <= l + 1; i++) x ^= mq[i];
        if (x == bd) begin
          m_hold = 1;
          m_plen = l;
          for (int i = 0; i < l; i++) m_pay[i] = mq[i + 2];
        end else begin
          m_crc = 1;
        end
        mq.delete();
      end
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == TO) begin
        m_to = 1;
        m_ticks = 0;
        mq.delete();
      end
    end
  endtask

  function automatic logic [20:0] model_status();
    return st(m_hold, 8'(m_flen), m_hold || (mq.size() != 0), {m_crc, m_lerr, m_to}, 8'(m_drop));
  endfunction

  // ------------------------------------------------------ random generation
  int sq[$];   // >= 0: byte to send, < 0: idle for -value cycles

  task automatic gen_chunk();
    int         kind, l, k;
    logic [7:0] x, b;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      sq.push_back($urandom_range(0, 255));
    end else if (kind == 1) begin
      sq.push_back(int'(SYNC));
      sq.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255));
    end else begin
      l = $urandom_range(1, MAXL);
      k = (kind == 3) ? $urandom_range(0, l) : l;
      sq.push_back(int'(SYNC));
      sq.push_back(l);
      x = 8'(l);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        sq.push_back(int'(b));
      end
      if (kind == 3) sq.push_back(-200);                               // truncated -> timeout
      else if (kind == 2) sq.push_back(int'(x ^ 8'($urandom_range(1, 255))));
      else sq.push_back(int'(x));
    end
    sq.push_back(-$urandom_range(0, 6));
  endtask

  task automatic random_phase(input int n);
    int         gap, v;
    bit         tk, bv, ack, hold_before;
    logic [7:0] bd;
    logic [3:0] addr;
    gap = 0;
    for (int c = 0; c < n; c++) begin
      bv   = 0;
      bd   = 8'($urandom_range(0, 255));
      tk   = ($urandom_range(0, 3) == 0);
      ack  = ($urandom_range(0, 15) == 0);
      addr = 4'($urandom_range(0, 15));
      if (gap > 0) begin
        gap--;
      end else begin
        if (sq.size() == 0) gen_chunk();
        if ($urandom_range(0, 3) != 0) begin
          v = sq.pop_front();
          if (v < 0) gap = -v;
          else begin
            bv = 1;
            bd = 8'(v);
          end
        end
      end
      hold_before = m_hold;
      model_step(tk, bv, bd, ack);
      cyc(tk, bv, bd, ack, addr);
      check($sformatf("rand_status_%0d", c), 32'(status()), 32'(model_status()));
      if ((hold_before || m_hold) && int'(addr) < m_plen)
        check($sformatf("rand_rd_%0d", c), 32'(bus.rd_data), 32'(m_pay[addr]));
    end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    logic [7:0] x, pay[16];
    vec_t       t;

    bus.tick = 0; bus.byte_valid = 0; bus.byte_data = 0; bus.frame_ack = 0; bus.rd_addr = 0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_status", 32'(status()), 32'(0));
    check("reset_rd_data", 32'(bus.rd_data), 32'(0));
    rst = 1'b0;

    // directed table
    fill_table();
    foreach (tbl[i]) begin
      t = tbl[i];
      cyc(1'b0, t.bv, t.bd, t.ack, t.addr);
      check($sformatf("tbl_%0d_status", i), 32'(status()), 32'(st(t.v, t.len, t.busy, t.err, 8'd0)));
      if (t.chk_rd) check($sformatf("tbl_%0d_rd", i), 32'(bus.rd_data), 32'(t.rd));
    end

    // maximum length frame
    sb(SYNC);
    sb(8'h10);
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i * 7 + 3);
      x ^= pay[i];
      sb(pay[i]);
    end
    check("maxlen_before_csum", 32'(status()), 32'(st(0, 16, 1, 0, 0)));
    sb(x);
    check("maxlen_accept", 32'(status()), 32'(st(1, 16, 1, 0, 0)));
    cyc(0, 0, 0, 0, 4'd15);
    check("maxlen_rd15", 32'(bus.rd_data), 32'(pay[15]));
    cyc(0, 0, 0, 1, 4'd0);
    check("maxlen_ack", 32'(status()), 32'(st(0, 16, 0, 0, 0)));

    // timeout: 30 ticks with no byte
    sb(SYNC); sb(8'h02); sb(8'hAA);
    for (int i = 1; i < TO; i++) cyc(1, 0, 0, 0, 0);
    check("timeout_tick29", 32'(status()), 32'(st(0, 2, 1, 0, 0)));
    cyc(1, 0, 0, 0, 0);
    check("timeout_tick30", 32'(status()), 32'(st(0, 2, 0, 3'b001, 0)));
    cyc(0, 0, 0, 0, 0);
    check("timeout_pulse_end", 32'(status()), 32'(st(0, 2, 0, 0, 0)));

    // timeout: byte lands on the 30th tick and wins
    sb(SYNC); sb(8'h02); sb(8'hAA);
    for (int i = 1; i < TO; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 8'hBB, 0, 0);
    check("timeout_byte_wins", 32'(status()), 32'(st(0, 2, 1, 0, 0)));
    sb(8'h02 ^ 8'hAA ^ 8'hBB);
    check("timeout_frame_ok", 32'(status()), 32'(st(1, 2, 1, 0, 0)));
    cyc(0, 0, 0, 1, 0);

    // overrun while holding
    sb(SYNC); sb(8'h01); sb(8'h55); sb(8'h54);
    cyc(0, 0, 0, 0, 0);
    check("overrun_rd_before", 32'(bus.rd_data), 32'(8'h55));
    for (int i = 0; i < 3; i++) sb(8'h11 + 8'(i));
    check("overrun_drop3", 32'(status()), 32'(st(1, 1, 1, 0, 3)));
    check("overrun_rd_after", 32'(bus.rd_data), 32'(8'h55));
    for (int i = 0; i < 300; i++) sb(8'(i));
    check("overrun_saturate", 32'(status()), 32'(st(1, 1, 1, 0, 255)));
    cyc(0, 1, 8'h00, 1, 0);
    check("overrun_ack", 32'(status()), 32'(st(0, 1, 0, 0, 255)));

    // asynchronous reset in the middle of a payload
    sb(SYNC); sb(8'h04); sb(8'h01); sb(8'h02);
    cyc(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_status", 32'(status()), 32'(0));
    check("async_reset_rd", 32'(bus.rd_data), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    sb(SYNC); sb(8'h01); sb(8'h55); sb(8'h54);
    check("after_reset_frame", 32'(status()), 32'(st(1, 1, 1, 0, 0)));
    cyc(0, 0, 0, 1, 0);

    // randomized phase against the packet model
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    random_phase(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
